// File: rtl/jam_cost_table.sv
// -----------------------------------------------------------------------------
// jam_cost_table
// Cost-storage stage in front of the JAM job-assignment engine.
//
// The block takes an 8x8 worker/job cost matrix as a row-major valid/ready
// stream and keeps it in a 64-entry register file. After the last beat it
// spends one cycle per row adding that row's minimum into LowerBound, which
// is a lower bound on the cost of any assignment. It then raises table_ready
// so JAM can start issuing (W,J) lookups on Cost.
//
// Ports:
//   CLK          clock; all state changes on the rising edge
//   RST          asynchronous, active-high reset
//   in_valid     stream beat valid
//   in_ready     block can accept a beat (IDLE and LOAD only)
//   in_data      cost entry, row-major order (W major, J minor)
//   in_last      marks the final beat of the matrix (beat 64)
//   clear        synchronous single-cycle request: drop table, return to IDLE
//   W, J         lookup worker / job index from JAM
//   Cost         mem[W*8+J], combinational read
//   table_ready  matrix loaded and lower bound computed
//   LowerBound   sum over rows of min(row)
//   lb_valid     LowerBound is valid
//   load_err     sticky framing error on the last load attempt
// -----------------------------------------------------------------------------
module jam_cost_table #(
  parameter int N  = 8,   // matrix dimension; the port widths below assume 8
  parameter int CW = 7,   // cost entry width
  parameter int BW = 10   // lower-bound width
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_data,
  input  logic          in_last,
  input  logic          clear,
  input  logic [2:0]    W,
  input  logic [2:0]    J,
  output logic [CW-1:0] Cost,
  output logic          table_ready,
  output logic [BW-1:0] LowerBound,
  output logic          lb_valid,
  output logic          load_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_READY = 2'd3
  } state_t;

  // Minimum of one packed row of N cost entries.
  function automatic logic [CW-1:0] row_min(input logic [N*CW-1:0] row);
    logic [CW-1:0] m;
    m = row[CW-1:0];
    for (int i = 1; i < N; i++) begin
      if (row[i*CW +: CW] < m) begin
        m = row[i*CW +: CW];
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

  state_t          state_r;
  state_t          state_n_s;
  logic [5:0]      idx_r;
  logic [2:0]      r_r;
  logic [BW-1:0]   lb_r;
  logic            load_err_r;
  logic            table_ready_r;
  logic            lb_valid_r;
  logic            in_ready_r;
  logic [CW-1:0]   mem_r [0:63];

  logic            accept_s;
  logic            wr_en_s;
  logic            frame_ok_s;
  logic            frame_bad_s;
  logic            in_ready_n_s;
  logic [N*CW-1:0] row_s;
  logic [CW-1:0]   row_min_s;

  // A beat is taken whenever the handshake completes; clear suppresses the write.
  assign accept_s    = in_valid && in_ready_r;
  assign wr_en_s     = accept_s && !clear;
  // Framing is only judged on beats accepted while in LOAD.
  assign frame_ok_s  = (idx_r == 6'd63) && in_last;
  assign frame_bad_s = in_last ^ (idx_r == 6'd63);

  // Gather the row currently being scanned and reduce it to its minimum.
  always_comb begin
    row_s = '0;
    for (int j = 0; j < N; j++) begin
      row_s[j*CW +: CW] = mem_r[{r_r, j[2:0]}];
    end
    row_min_s = row_min(row_s);
  end

  // Next-state logic; clear overrides everything and returns to IDLE.
  always_comb begin
    state_n_s = state_r;
    if (clear) begin
      state_n_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_n_s = ST_LOAD;
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (accept_s && frame_ok_s) begin
            state_n_s = ST_SCAN;
          end else if (accept_s && frame_bad_s) begin
            state_n_s = ST_IDLE;
          end else begin
            state_n_s = ST_LOAD;
          end
        end
        ST_SCAN: begin
          if (r_r == 3'd7) begin
            state_n_s = ST_READY;
          end else begin
            state_n_s = ST_SCAN;
          end
        end
        ST_READY: begin
          state_n_s = ST_READY;
        end
        default: begin
          state_n_s = ST_IDLE;
        end
      endcase
    end
    in_ready_n_s = (state_n_s == ST_IDLE) || (state_n_s == ST_LOAD);
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Beat counter, scan row, lower-bound accumulator and status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_r         <= 6'd0;
      r_r           <= 3'd0;
      lb_r          <= '0;
      load_err_r    <= 1'b0;
      table_ready_r <= 1'b0;
      lb_valid_r    <= 1'b0;
      in_ready_r    <= 1'b1;
    end else if (clear) begin
      idx_r         <= 6'd0;
      r_r           <= 3'd0;
      lb_r          <= '0;
      load_err_r    <= 1'b0;
      table_ready_r <= 1'b0;
      lb_valid_r    <= 1'b0;
      in_ready_r    <= 1'b1;
    end else begin
      in_ready_r <= in_ready_n_s;
      // Flags follow the READY state one edge later, giving the 9-edge
      // latency from the last beat to table_ready.
      table_ready_r <= (state_r == ST_READY);
      lb_valid_r    <= (state_r == ST_READY);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            idx_r      <= 6'd1;
            load_err_r <= 1'b0;
          end else begin
            idx_r <= idx_r;
          end
        end
        ST_LOAD: begin
          if (accept_s && frame_ok_s) begin
            idx_r <= 6'd0;
            r_r   <= 3'd0;
            lb_r  <= '0;
          end else if (accept_s && frame_bad_s) begin
            idx_r      <= 6'd0;
            load_err_r <= 1'b1;
          end else if (accept_s) begin
            idx_r <= idx_r + 6'd1;
          end else begin
            idx_r <= idx_r;
          end
        end
        ST_SCAN: begin
          lb_r <= lb_r + {{(BW-CW){1'b0}}, row_min_s};
          r_r  <= r_r + 3'd1;
        end
        ST_READY: begin
          lb_r <= lb_r;
        end
        default: begin
          idx_r <= 6'd0;
          r_r   <= 3'd0;
        end
      endcase
    end
  end

  // Cost storage; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[idx_r] <= in_data;
    end else begin
      mem_r[idx_r] <= mem_r[idx_r];
    end
  end

  assign Cost        = mem_r[{W, J}];
  assign in_ready    = in_ready_r;
  assign table_ready = table_ready_r;
  assign lb_valid    = lb_valid_r;
  assign LowerBound  = lb_r;
  assign load_err    = load_err_r;

endmodule

// File: tb/tb_jam_cost_table.sv
// -----------------------------------------------------------------------------
// tb_jam_cost_table
// Self-checking bench for jam_cost_table. Expected lower bounds and Cost
// lookups come from a bench-side model of the matrix and are queued when the
// stimulus is driven, then popped when the DUT presents the result.
// -----------------------------------------------------------------------------
module tb_jam_cost_table;

  logic       CLK = 1'b0;
  logic       RST;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data;
  logic       in_last;
  logic       clear;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       table_ready;
  logic [9:0] LowerBound;
  logic       lb_valid;
  logic       load_err;

  int checks = 0;
  int errors = 0;

  logic [6:0]  model [64];
  logic [31:0] exp_q [$];

  jam_cost_table dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .clear       (clear),
    .W           (W),
    .J           (J),
    .Cost        (Cost),
    .table_ready (table_ready),
    .LowerBound  (LowerBound),
    .lb_valid    (lb_valid),
    .load_err    (load_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_lb();
    logic [31:0] sum;
    logic [6:0]  m;
    sum = 32'd0;
    for (int r = 0; r < 8; r++) begin
      m = model[r*8];
      for (int c = 1; c < 8; c++) begin
        if (model[r*8+c] < m) m = model[r*8+c];
      end
      sum = sum + {25'd0, m};
    end
    return sum;
  endfunction

  // Send n_beats from the model; in_last goes high on beat number last_at
  // (1-based, 0 = never). gap_mode 1 drives valid in a 1,0,0,1 pattern with
  // junk data and in_last=1 on the idle cycles. Called at posedge+1.
  task automatic load(input int n_beats, input int last_at, input int gap_mode, input bit push_exp);
    int  beat;
    int  cyc;
    bit  v;
    beat = 0;
    cyc  = 0;
    while (beat < n_beats) begin
      v = (gap_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      in_valid = v;
      if (v) begin
        in_data = model[beat];
        in_last = (beat + 1 == last_at);
      end else begin
        in_data = 7'h55;
        in_last = 1'b1;
      end
      @(posedge CLK); #1;
      if (v) begin
        beat++;
        if (beat == 1) check_val("load_err_clr_first_beat", {31'd0, load_err}, 32'd0);
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (push_exp) exp_q.push_back(model_lb());
  endtask

  // Count edges from the last accepted beat to table_ready, then score LB.
  task automatic wait_ready();
    int n;
    n = 0;
    check_val("tr_low_after_last", {31'd0, table_ready}, 32'd0);
    while (!table_ready && n < 30) begin
      @(posedge CLK); #1;
      n++;
    end
    check_val("ready_latency", n, 32'd9);
    check_val("lb_valid", {31'd0, lb_valid}, 32'd1);
    check_val("in_ready_in_ready_state", {31'd0, in_ready}, 32'd0);
    if (exp_q.size() > 0) begin
      check_val("lower_bound", {22'd0, LowerBound}, exp_q.pop_front());
    end else begin
      check_val("scoreboard_empty_lb", 32'd1, 32'd0);
    end
  endtask

  task automatic read_cost(input string tag, input logic [2:0] w, input logic [2:0] j, input logic [6:0] exp);
    W = w;
    J = j;
    exp_q.push_back({25'd0, exp});
    @(negedge CLK);
    if (exp_q.size() > 0) begin
      check_val(tag, {25'd0, Cost}, exp_q.pop_front());
    end else begin
      check_val("scoreboard_empty_cost", 32'd1, 32'd0);
    end
    @(posedge CLK); #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge CLK); #1;
    clear = 1'b0;
  endtask

  task automatic random_reads(input int count);
    logic [2:0] w;
    logic [2:0] j;
    for (int i = 0; i < count; i++) begin
      w = 3'($urandom_range(0, 7));
      j = 3'($urandom_range(0, 7));
      read_cost("cost_random", w, j, model[{w, j}]);
    end
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_data = 7'd0; in_last = 1'b0;
    clear = 1'b0; W = 3'd0; J = 3'd0;
    repeat (2) @(posedge CLK);
    #1;
    check_val("rst_in_ready",    {31'd0, in_ready},    32'd1);
    check_val("rst_table_ready", {31'd0, table_ready}, 32'd0);
    check_val("rst_lb_valid",    {31'd0, lb_valid},    32'd0);
    check_val("rst_lower_bound", {22'd0, LowerBound},  32'd0);
    check_val("rst_load_err",    {31'd0, load_err},    32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Ramp matrix k mod 100, continuous valid.
    for (int k = 0; k < 64; k++) model[k] = 7'(k % 100);
    load(64, 64, 0, 1'b1);
    wait_ready();
    check_val("lb_ramp_224", {22'd0, LowerBound}, 32'd224);
    read_cost("cost_w3_j5", 3'd3, 3'd5, 7'd29);
    read_cost("cost_w7_j7", 3'd7, 3'd7, 7'd63);
    random_reads(4);
    check_val("lb_stable_ready", {22'd0, LowerBound}, 32'd224);

    // clear while READY.
    pulse_clear();
    check_val("clr_table_ready", {31'd0, table_ready}, 32'd0);
    check_val("clr_lb_valid",    {31'd0, lb_valid},    32'd0);
    check_val("clr_lower_bound", {22'd0, LowerBound},  32'd0);
    check_val("clr_in_ready",    {31'd0, in_ready},    32'd1);

    // Same matrix with gaps.
    load(64, 64, 1, 1'b1);
    wait_ready();
    read_cost("gap_cost_w3_j5", 3'd3, 3'd5, 7'd29);
    random_reads(4);
    pulse_clear();

    // Early last on beat 40.
    load(40, 40, 0, 1'b0);
    check_val("early_last_err",    {31'd0, load_err},    32'd1);
    check_val("early_last_tr",     {31'd0, table_ready}, 32'd0);
    check_val("early_last_ready",  {31'd0, in_ready},    32'd1);
    repeat (3) @(posedge CLK);
    #1;
    check_val("early_last_sticky", {31'd0, load_err},    32'd1);

    // Clean random load clears the error on its first beat.
    for (int k = 0; k < 64; k++) model[k] = 7'($urandom_range(0, 127));
    load(64, 64, 0, 1'b1);
    wait_ready();
    random_reads(6);
    pulse_clear();

    // Missing last on beat 64.
    load(64, 0, 0, 1'b0);
    check_val("missing_last_err",   {31'd0, load_err},    32'd1);
    check_val("missing_last_tr",    {31'd0, table_ready}, 32'd0);
    check_val("missing_last_ready", {31'd0, in_ready},    32'd1);

    // Extremes.
    for (int k = 0; k < 64; k++) model[k] = 7'd127;
    load(64, 64, 0, 1'b1);
    wait_ready();
    check_val("lb_all127_1016", {22'd0, LowerBound}, 32'd1016);
    pulse_clear();
    for (int k = 0; k < 64; k++) model[k] = 7'd0;
    load(64, 64, 0, 1'b1);
    wait_ready();
    check_val("lb_all0", {22'd0, LowerBound}, 32'd0);
    pulse_clear();

    // clear together with beat 20: the table still holds zeros.
    for (int k = 0; k < 64; k++) model[k] = 7'(k + 1);
    load(19, 0, 0, 1'b0);
    in_valid = 1'b1; in_data = model[19]; in_last = 1'b0; clear = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; clear = 1'b0;
    check_val("clr_beat20_in_ready", {31'd0, in_ready},    32'd1);
    check_val("clr_beat20_tr",       {31'd0, table_ready}, 32'd0);
    check_val("clr_beat20_err",      {31'd0, load_err},    32'd0);
    read_cost("clr_beat20_not_written", 3'd2, 3'd3, 7'd0);
    read_cost("clr_beat19_written",     3'd2, 3'd2, 7'd19);
    load(64, 64, 0, 1'b1);
    wait_ready();
    random_reads(4);
    pulse_clear();

    // RST during SCAN cycle 4.
    for (int k = 0; k < 64; k++) model[k] = 7'($urandom_range(10, 127));
    load(64, 64, 0, 1'b0);
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_val("rst_scan_in_ready",    {31'd0, in_ready},    32'd1);
    check_val("rst_scan_table_ready", {31'd0, table_ready}, 32'd0);
    check_val("rst_scan_lb_valid",    {31'd0, lb_valid},    32'd0);
    check_val("rst_scan_lower_bound", {22'd0, LowerBound},  32'd0);
    check_val("rst_scan_load_err",    {31'd0, load_err},    32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    load(64, 64, 0, 1'b1);
    wait_ready();
    random_reads(4);

    check_val("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
Upstream cost-storage stage for the JAM job-assignment engine.
- Accepts an 8x8 worker/job cost matrix (7-bit entries) as a row-major valid/ready stream.
- Stores the matrix in a 64-entry register file and serves JAM's (W,J) lookups on Cost.
- After loading, computes the sum of per-row minima (a lower bound on any assignment cost) and flags the table ready so JAM may start.

Parameters:
N, 8, matrix dimension (workers = jobs); fixed at 8 in this revision
CW, 7, cost entry width
BW, 10, lower-bound / total-cost width

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset, asynchronous, active-high
in_valid  input  1  stream beat valid
in_ready  output  1  block can accept a beat
in_data  input  7  cost entry, row-major order (W major, J minor)
in_last  input  1  marks final beat of the matrix (beat 64)
clear  input  1  synchronous single-cycle request: drop table, return to IDLE
W  input  3  lookup worker index (driven by JAM)
J  input  3  lookup job index (driven by JAM)
Cost  output  7  mem[W*8+J], combinational read
table_ready  output  1  matrix loaded and lower bound computed
LowerBound  output  10  sum over rows of min(row)
lb_valid  output  1  LowerBound is valid
load_err  output  1  sticky framing error on the last load attempt

Behaviour:
- Reset values:
  - Outputs: in_ready=1, table_ready=0, lb_valid=0, LowerBound=0, load_err=0.
  - State and counters: state=IDLE, beat counter idx=0, scan row r=0.
  - Memory contents are not reset; Cost is don't-care while table_ready=0.
- States: IDLE, LOAD, SCAN, READY.
- A beat is accepted on a rising edge where in_valid && in_ready. Accepted data is written to mem[idx], then idx increments (6-bit).
- in_ready = 1 in IDLE and LOAD, 0 in SCAN and READY.
- IDLE:
  - First accepted beat writes mem[0], sets idx=1, clears load_err, and goes to LOAD.
  - Without a beat, stays in IDLE.
- LOAD:
  - Accepted beat with idx=63 and in_last=1: go to SCAN, idx=0, r=0, LowerBound=0.
  - Accepted beat with in_last=1 and idx<63 (early last), or idx=63 with in_last=0 (missing last): set load_err=1, go to IDLE, idx=0. The partial table is discarded.
  - Cycles without a beat hold all state; gaps of any length are legal.
- SCAN:
  - Exactly 8 cycles, one per row r=0..7.
  - Each cycle: LowerBound <= LowerBound + min(mem[r*8+0..7]), computed combinationally over 8 entries; r increments.
  - No overflow: 8*127 = 1016 < 1024.
  - After the r=7 cycle, go to READY; table_ready and lb_valid are 1 from the next edge on.
  - Latency from the edge accepting the last beat to table_ready=1 is 9 rising edges.
- READY:
  - Holds the table. table_ready=1, lb_valid=1, and LowerBound is stable.
  - Cost = mem[{W,J}] combinationally, settled within the same cycle. JAM's half-cycle (negedge) sampling of Cost is legal.
- clear:
  - In any state: next edge goes to IDLE, table_ready=0, lb_valid=0, LowerBound=0, idx=0, r=0. load_err is also cleared.
  - clear takes priority over a simultaneous accepted beat; that beat is dropped and not written.
- RST asserted mid-LOAD or mid-SCAN immediately returns all outputs to reset values. A fresh full load is required afterwards.
- Cost read during LOAD or SCAN returns current memory contents (possibly stale) and must not be relied on.
- W, J, Cost have no handshake; the consumer must gate on table_ready.

Test Plan:
- Load mem[k] = k mod 100 (k=0..63), in_valid held high, in_last on beat 64:
  - table_ready rises 9 edges after the last beat.
  - LowerBound = 0+8+16+24+32+40+48+56 = 224.
  - Read W=3,J=5 gives Cost=29; W=7,J=7 gives Cost=63.
- Same load with in_valid toggling 1,0,0,1 pattern: identical final table and LowerBound; memory and idx unchanged on gap cycles.
- Framing errors:
  - in_last asserted on beat 40: load_err=1, state IDLE, table_ready=0, in_ready=1.
  - Next clean 64-beat load clears load_err on its first beat.
- All-127 matrix: LowerBound=1016, no wrap. All-zero matrix: LowerBound=0, lb_valid=1.
- Abort cases:
  - clear pulsed in READY: table_ready and lb_valid drop next edge, LowerBound=0.
  - clear asserted on the same edge as beat 20 during LOAD: beat not written, idx=0, state IDLE.
- RST pulsed during SCAN cycle 4: outputs at reset values immediately; subsequent full load completes with the correct LowerBound.
